// File: rtl/flash_arb_pkg.sv
// Shared constants for the flash access arbiter: region map, FSM encoding, port indices.
package flash_arb_pkg;

    localparam logic [31:0] CS0_BASE  = 32'h0000_0000;
    localparam logic [31:0] CS0_LIMIT = 32'h07FF_FFFF;
    localparam logic [31:0] CS1_BASE  = 32'h0800_0000;
    localparam logic [31:0] CS1_LIMIT = 32'h0FFF_FFFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic PORT_FETCH  = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    localparam logic REGION_CS0 = 1'b0;
    localparam logic REGION_CS1 = 1'b1;

endpackage

// File: rtl/flash_region_decode.sv
// Combinational address decoder: maps an address onto the CS0/CS1 flash regions.
module flash_region_decode
    import flash_arb_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic [AW-1:0] addr,
    output logic          region,
    output logic          oor
);

    // Both regions are power-of-two sized and aligned, so a masked compare is exact.
    localparam logic [AW-1:0] CS0_MASK = ~AW'(CS0_LIMIT ^ CS0_BASE);
    localparam logic [AW-1:0] CS1_MASK = ~AW'(CS1_LIMIT ^ CS1_BASE);

    logic in_cs0;
    logic in_cs1;

    assign in_cs0 = ((addr ^ AW'(CS0_BASE)) & CS0_MASK) == '0;
    assign in_cs1 = ((addr ^ AW'(CS1_BASE)) & CS1_MASK) == '0;
    assign region = in_cs1 ? REGION_CS1 : REGION_CS0;
    assign oor    = !(in_cs0 || in_cs1);

endmodule

// File: rtl/flash_access_arbiter.sv
// Round-robin arbiter sharing the two program flash devices between fetch and loader ports,
// with region decode, write protection and a programmable wait-state sequencer.
module flash_access_arbiter
    import flash_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int WAIT_CYCLES = 3
) (
    input  logic          clk,
    input  logic          nRESET,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          ack0,
    output logic          err0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic          we1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic          err1,
    output logic [DW-1:0] rdata,
    input  logic          wp_unlock,
    output logic          CS0,
    output logic          CS1,
    output logic          WP,
    output logic [26:0]   flash_addr,
    output logic          flash_we,
    output logic [DW-1:0] flash_wdata,
    input  logic [DW-1:0] flash_rdata
);

    logic [1:0]    state;
    logic          last_gnt;
    logic          gnt;
    logic [3:0]    cnt;
    logic          h_we;
    logic          h_fail;

    logic          win;
    logic [AW-1:0] win_addr;
    logic          win_we;
    logic          dec_region;
    logic          dec_oor;
    logic          reject;
    logic          write_ok;

    // Port 0 is read-only, so only the loader can ever present a write.
    assign win      = (req0 && req1) ? ~last_gnt : (req0 ? PORT_FETCH : PORT_LOADER);
    assign win_addr = (win == PORT_LOADER) ? addr1 : addr0;
    assign win_we   = (win == PORT_LOADER) && we1;

    flash_region_decode #(.AW(AW)) u_decode (
        .addr   (win_addr),
        .region (dec_region),
        .oor    (dec_oor)
    );

    assign reject   = dec_oor || (win_we && ((dec_region == REGION_CS0) || !wp_unlock));
    assign write_ok = win_we && !reject;

    // NOTE: every output is a flop in this async-reset block, so asserting nRESET
    // drops CS0/CS1/flash_we immediately and discards any ack in flight.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state       <= ST_IDLE;
            last_gnt    <= PORT_LOADER;
            gnt         <= PORT_FETCH;
            cnt         <= '0;
            h_we        <= 1'b0;
            h_fail      <= 1'b0;
            CS0         <= 1'b0;
            CS1         <= 1'b0;
            WP          <= 1'b1;
            flash_we    <= 1'b0;
            flash_addr  <= '0;
            flash_wdata <= '0;
            rdata       <= '0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        gnt        <= win;
                        h_we       <= win_we;
                        h_fail     <= reject;
                        flash_addr <= win_addr[26:0];
                        if (win_we) begin
                            flash_wdata <= wdata1;
                        end
                        CS0      <= !reject && (dec_region == REGION_CS0);
                        CS1      <= !reject && (dec_region == REGION_CS1);
                        flash_we <= write_ok;
                        WP       <= !write_ok;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (h_fail) begin
                        ack0  <= (gnt == PORT_FETCH);
                        ack1  <= (gnt == PORT_LOADER);
                        err0  <= (gnt == PORT_FETCH);
                        err1  <= (gnt == PORT_LOADER);
                        state <= ST_DONE;
                    end else begin
                        cnt   <= 4'(WAIT_CYCLES - 1);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        if (!h_we) begin
                            rdata <= flash_rdata;
                        end
                        CS0      <= 1'b0;
                        CS1      <= 1'b0;
                        flash_we <= 1'b0;
                        WP       <= 1'b1;
                        ack0     <= (gnt == PORT_FETCH);
                        ack1     <= (gnt == PORT_LOADER);
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    ack0     <= 1'b0;
                    ack1     <= 1'b0;
                    err0     <= 1'b0;
                    err1     <= 1'b0;
                    last_gnt <= gnt;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_access_arbiter.sv
// Scoreboard bench for flash_access_arbiter: stimulus pushes expected acks, a monitor pops and compares.
module tb_flash_access_arbiter;

    localparam int W = 3;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        nRESET = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we1 = 1'b0, wp_unlock = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata1 = '0;
    logic        ack0, ack1, err0, err1, CS0, CS1, WP, flash_we;
    logic [31:0] rdata, flash_wdata, flash_rdata;
    logic [26:0] flash_addr;

    logic [31:0] f0_word = '0, f1_word = '0, model_rdata = '0, cs_age = '0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];

    flash_access_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(W)) dut (
        .clk(clk), .nRESET(nRESET),
        .req0(req0), .addr0(addr0), .ack0(ack0), .err0(err0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1), .ack1(ack1), .err1(err1),
        .rdata(rdata), .wp_unlock(wp_unlock),
        .CS0(CS0), .CS1(CS1), .WP(WP),
        .flash_addr(flash_addr), .flash_we(flash_we), .flash_wdata(flash_wdata),
        .flash_rdata(flash_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash device model: data is only valid on the last wait cycle of a select.
    always @(posedge clk) cs_age <= (CS0 || CS1) ? cs_age + 32'd1 : 32'd0;
    assign flash_rdata = (cs_age == 32'(W)) ? (CS0 ? f0_word : (CS1 ? f1_word : 32'h0))
                                            : (32'hBAD0_0000 | cs_age);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (nRESET) begin
            if (CS0 && CS1) check("cs_exclusive", 1, 0);
            if ((err0 && !ack0) || (err1 && !ack1)) check("err_without_ack", 1, 0);
            if (ack0 && ack1) check("dual_ack", 1, 0);
            if (ack0 || ack1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_port"}, 32'(ack1), 32'(e.port));
                    check({e.name, "_err"}, 32'(ack1 ? err1 : err0), 32'(e.err));
                    check({e.name, "_rdata"}, rdata, e.rdata);
                    check({e.name, "_latency"}, cyc, e.cyc);
                end
            end
        end
    end

    task automatic txn(input string name, input bit port, input logic [31:0] addr,
                       input bit we, input logic [31:0] wdata, input bit unlock,
                       input bit exp_err, input logic [31:0] word, input int drop_at,
                       input int exp_cs0, input int exp_cs1, input int exp_we);
        int  cs0_n = 0, cs1_n = 0, we_n = 0, wpl_n = 0, bad = 0;
        bit  done = 0;
        exp_t e;
        @(negedge clk);
        wp_unlock = unlock;
        if (port) begin
            addr1 = addr; we1 = we; wdata1 = wdata; f1_word = word; req1 = 1'b1;
        end else begin
            addr0 = addr; f0_word = word; req0 = 1'b1;
        end
        if (!exp_err && !we) model_rdata = word;
        e.port = port; e.err = exp_err; e.rdata = model_rdata; e.name = name;
        e.cyc = cyc + 1 + (exp_err ? 1 : W + 1);
        exp_q.push_back(e);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 0) begin
                // Inputs after grant must be ignored by the holding registers.
                addr0 = addr0 ^ 32'h0800_0F0F;
                addr1 = addr1 ^ 32'h0800_0F0F;
                wdata1 = ~wdata1;
                we1 = ~we1;
            end
            if (drop_at > 0 && n == drop_at) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            cs0_n += int'(CS0);
            cs1_n += int'(CS1);
            we_n  += int'(flash_we);
            wpl_n += int'(!WP);
            if ((CS0 || CS1) && flash_addr !== addr[26:0]) bad++;
            if (flash_we && flash_wdata !== wdata) bad++;
            if (port ? ack1 : ack0) begin
                req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
                done = 1;
                break;
            end
        end
        if (!done) check({name, "_ack_timeout"}, 0, 1);
        check({name, "_cs0_cycles"}, cs0_n, exp_cs0);
        check({name, "_cs1_cycles"}, cs1_n, exp_cs1);
        check({name, "_we_cycles"}, we_n, exp_we);
        check({name, "_wp_low_cycles"}, wpl_n, exp_we);
        check({name, "_held_addr_data"}, bad, 0);
        wp_unlock = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k, acks, conflicts, bad_addr;
        exp_t e;
        bit   done;

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_cs0", CS0, 0);
        check("rst_cs1", CS1, 0);
        check("rst_wp", WP, 1);
        check("rst_flash_we", flash_we, 0);
        check("rst_acks", {ack0, ack1, err0, err1}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_flash_addr", flash_addr, 0);
        check("rst_flash_wdata", flash_wdata, 0);
        nRESET = 1'b1;
        repeat (2) @(negedge clk);

        txn("read_cs0", 0, 32'h0000_0BCD, 0, 0, 0, 0, 32'hA5A5_0001, 0, W + 1, 0, 0);
        txn("oor_read", 1, 32'h2000_0DEF, 0, 0, 0, 1, 32'h1111_1111, 0, 0, 0, 0);
        txn("wp_locked", 1, 32'h0800_0010, 1, 32'hCAFE_0010, 0, 1, 0, 0, 0, 0, 0);
        txn("wp_unlocked", 1, 32'h0800_0010, 1, 32'hCAFE_0010, 1, 0, 0, 0, 0, W + 1, W + 1);
        txn("cs0_write", 1, 32'h0000_0040, 1, 32'h0BAD_0040, 1, 1, 0, 0, 0, 0, 0);
        txn("cs0_top", 0, 32'h07FF_FFFF, 0, 0, 0, 0, 32'h7777_0000, 0, W + 1, 0, 0);
        txn("req0_drop", 0, 32'h0000_0200, 0, 0, 0, 0, 32'h1234_5678, 2, W + 1, 0, 0);

        // Reset during WAIT: selects drop at once and no ack follows.
        @(negedge clk);
        addr0 = 32'h0000_0300; f0_word = 32'h3333_3333; req0 = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_cs0_before", CS0, 1);
        #2 nRESET = 1'b0;
        #1;
        check("midrst_cs0", CS0, 0);
        check("midrst_cs1", CS1, 0);
        check("midrst_we_wp", {flash_we, WP}, 2'b01);
        req0 = 1'b0;
        model_rdata = '0;
        repeat (3) @(negedge clk);
        nRESET = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_ack", {ack0, ack1}, 0);
        check("midrst_rdata", rdata, 0);

        txn("read_after_rst", 0, 32'h0000_0400, 0, 0, 0, 0, 32'h0F0F_1234, 0, W + 1, 0, 0);
        txn("cs1_top", 1, 32'h0FFF_FFFF, 0, 0, 0, 0, 32'h8888_FFFF, 0, 0, W + 1, 0);
        txn("oor_low", 1, 32'h1000_0000, 0, 0, 0, 1, 32'h2222_2222, 0, 0, 0, 0);

        // Both ports held: pointer starts at port 1, so port 0 wins, then they alternate.
        @(negedge clk);
        addr0 = 32'h0000_0100; addr1 = 32'h0800_0CBA; we1 = 1'b0;
        f0_word = 32'h0000_F00D; f1_word = 32'h0000_F11D;
        req0 = 1'b1; req1 = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            e.port = i[0]; e.err = 0; e.rdata = i[0] ? f1_word : f0_word;
            e.cyc = k + W + 1 + i * (W + 3);
            e.name = $sformatf("rr%0d", i);
            exp_q.push_back(e);
        end
        model_rdata = f1_word;
        acks = 0; conflicts = 0; bad_addr = 0; done = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (CS0 && flash_addr !== 27'h0000100) bad_addr++;
            if (CS1 && flash_addr !== 27'h0000CBA) bad_addr++;
            if (CS0 && CS1) conflicts++;
            acks += int'(ack0) + int'(ack1);
            if (acks == 4) begin
                req0 = 1'b0; req1 = 1'b0;
                done = 1;
                break;
            end
        end
        if (!done) check("rr_ack_timeout", 0, 1);
        check("rr_flash_addr", bad_addr, 0);
        check("rr_cs_conflicts", conflicts, 0);

        repeat (8) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
